// File: rtl/queue_datapath.sv
// Storage and pointer datapath of the RAM queue: executes enqueue/dequeue strobes
// from the control FSM and reports empty/full status plus a sticky protocol error.
module queue_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              add,
  input  logic              remove,
  input  logic              update,
  input  logic              op_select,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              underflow,
  output logic              overflow,
  output logic [ADDR_W:0]   count,
  output logic              protocol_err
);

  localparam int unsigned     DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              perr_q, perr_d;

  logic enq, deq, illegal;

  assign underflow = (count_q == '0);
  assign overflow  = (count_q == FULL);

  assign enq = update & add & ~remove & ~op_select & ~overflow;
  assign deq = update & remove & ~add & op_select & ~underflow;
  // Any qualified request that is neither a legal enqueue nor a legal dequeue.
  assign illegal = update & (add | remove) & ~enq & ~deq;

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    perr_d       = perr_q | illegal;
    if (enq) begin
      tail_d  = tail_q + 1'b1;
      count_d = count_q + 1'b1;
    end else if (deq) begin
      head_d       = head_q + 1'b1;
      count_d      = count_q - 1'b1;
      data_out_d   = mem_q[head_q];
      data_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      perr_q       <= perr_d;
    end
  end

  // RAM is deliberately unreset; an empty queue never reads an unwritten entry.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign count        = count_q;
  assign protocol_err = perr_q;

endmodule
